// File: rtl/fx2_pkg.sv
// Shared types and constants for the FX2 slave-FIFO sequencer.
// Imported by the arbiter top.
package fx2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_XFER,
        TX_ADDR,
        TX_XFER,
        TX_PKTEND
    } fx2_state_t;

    typedef enum logic {
        GNT_RX = 1'b0,
        GNT_TX = 1'b1
    } fx2_grant_t;

    localparam logic [1:0] ADDR_EP2 = 2'b00;
    localparam logic [1:0] ADDR_EP6 = 2'b10;

endpackage

// File: rtl/fx2_fifo_arbiter.sv
// FX2 slave-FIFO sequencer: shares FD between EP2 OUT reads and
// EP6 IN writes with round-robin grants and bounded bursts.
module fx2_fifo_arbiter
    import fx2_pkg::*;
#(
    parameter int unsigned BURST_MAX = 64
) (
    input  logic       sys_clk,
    input  logic       RESET,
    input  logic       ep2_empty_n,
    input  logic       ep6_full_n,
    output logic       SLOE,
    output logic       SLRD,
    output logic       SLWR,
    output logic [1:0] FIFOADR,
    output logic       PKTEND,
    input  logic [7:0] FDI,
    output logic [7:0] FDO,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       busy
);

    // Count value at which the current strobe is the final one of a grant.
    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    fx2_state_t state_q;
    fx2_state_t state_d;
    fx2_grant_t last_q;
    fx2_grant_t last_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       hold_q;
    logic       hold_d;
    logic [1:0] adr_q;
    logic [1:0] adr_d;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic [7:0] fdo_q;

    logic rx_req;
    logic tx_req;
    logic rd_en;
    logic wr_en;
    logic burst_end;

    // Strobe decode: registered state gated by the live flags, so a
    // flag dropping in a cycle suppresses that cycle's strobe.
    always_comb begin
        rx_req    = ep2_empty_n & rx_ready;
        tx_req    = ep6_full_n & tx_valid;
        rd_en     = (state_q == RX_XFER) & rx_req;
        wr_en     = (state_q == TX_XFER) & tx_req;
        burst_end = (cnt_q == BURST_LAST);
    end

    // Next-state, grant pointer, burst counter and idle hold-off.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        adr_d   = adr_q;
        unique case (state_q)
            IDLE: begin
                cnt_d  = 8'd0;
                hold_d = 1'b0;
                if (rx_req && (!tx_req || last_q == GNT_TX)) begin
                    state_d = RX_ADDR;
                    adr_d   = ADDR_EP2;
                end else if (tx_req) begin
                    state_d = TX_ADDR;
                    adr_d   = ADDR_EP6;
                end
            end
            RX_ADDR: begin
                state_d = RX_XFER;
            end
            RX_XFER: begin
                hold_d = ~rx_ready;
                if (rd_en) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (!ep2_empty_n
                    || (!rx_ready && hold_q)
                    || (rd_en && burst_end)) begin
                    state_d = IDLE;
                    last_d  = GNT_RX;
                end
            end
            TX_ADDR: begin
                state_d = TX_XFER;
            end
            TX_XFER: begin
                hold_d = ~tx_valid;
                if (wr_en) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (wr_en && tx_last) begin
                    state_d = TX_PKTEND;
                end else if (!ep6_full_n
                    || (!tx_valid && hold_q)
                    || (wr_en && burst_end)) begin
                    state_d = IDLE;
                    last_d  = GNT_TX;
                end
            end
            TX_PKTEND: begin
                state_d = IDLE;
                last_d  = GNT_TX;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register; reset parks the bus with RX winning first.
    always_ff @(posedge sys_clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            last_q  <= GNT_TX;
            cnt_q   <= 8'd0;
            hold_q  <= 1'b0;
            adr_q   <= ADDR_EP2;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            adr_q   <= adr_d;
        end
    end

    // Datapath: capture read bytes, remember the last written byte.
    always_ff @(posedge sys_clk or negedge RESET) begin
        if (!RESET) begin
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            fdo_q      <= 8'd0;
        end else begin
            rx_valid_q <= rd_en;
            if (rd_en) begin
                rx_data_q <= FDI;
            end
            if (wr_en) begin
                fdo_q <= tx_data;
            end
        end
    end

    // Output decode; FD holds the last written byte between strobes.
    always_comb begin
        SLOE     = ~((state_q == RX_ADDR) | (state_q == RX_XFER));
        SLRD     = ~rd_en;
        SLWR     = ~wr_en;
        PKTEND   = ~(state_q == TX_PKTEND);
        FIFOADR  = adr_q;
        FDO      = wr_en ? tx_data : fdo_q;
        tx_ready = wr_en;
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        busy     = (state_q != IDLE);
    end

endmodule
